// File: rtl/softmax_seq_ctrl.sv
// Sequenced softmax over an N-element Q4.12 vector using one shared pow2 and one shared log2 approximator.
// Optional natural-base scaling of the exponent is enabled with the macro SOFTMAX_LOG2E_SCALE_EN.

module pow2_approx (
  input  logic signed [15:0] i_x,
  output logic        [15:0] o_y
);
  logic [31:0] w_mant;
  logic [31:0] w_tmp;
  logic [3:0]  w_nk;

  // Mitchell form: 2^x ~= (1 + frac) << floor(x), saturated to the 16-bit unsigned range
  always_comb begin
    w_mant = {19'd0, 1'b1, i_x[11:0]};
    w_nk   = (~i_x[15:12]) + 4'd1;
    if (!i_x[15]) w_tmp = w_mant << i_x[14:12];
    else          w_tmp = w_mant >> w_nk;
    o_y = (|w_tmp[31:16]) ? 16'hFFFF : w_tmp[15:0];
  end
endmodule

module log2_approx (
  input  logic        [15:0] i_x,
  output logic signed [15:0] o_y
);
  logic [3:0]         w_p;
  logic [31:0]        w_rem;
  logic [31:0]        w_frac;
  logic signed [31:0] w_int;

  // Mitchell form: log2(v) ~= msb position + mantissa bits below the msb taken as the fraction
  always_comb begin
    w_p = '0;
    for (int b = 0; b < 16; b++) begin
      if (i_x[b]) w_p = 4'(b);
    end
    w_rem  = {16'd0, i_x} & ~(32'd1 << w_p);
    w_frac = (w_rem << 12) >> w_p;
    w_int  = $signed({28'd0, w_p}) - 32'sd12;
    o_y    = (i_x == 16'd0) ? 16'sh8000 : 16'((w_int <<< 12) + $signed(w_frac));
  end
endmodule

module softmax_seq_ctrl #(
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic        [15:0] out_data,
  output logic               out_last,
  output logic               done,
  output logic        [2:0]  dbg_state
);
  localparam int ACC_W = 16 + LOG2N;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXP, S_LOG, S_OUT} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds data stable while valid is high and ready is low.
  state_t                   r_state, w_next;
  logic        [LOG2N-1:0]  r_idx;
  logic signed [15:0]       r_max;
  logic        [ACC_W-1:0]  r_acc;
  logic signed [15:0]       r_lse;
  logic        [15:0]       r_out_data;
  logic                     r_out_valid;
  logic                     r_done;
  logic signed [15:0]       r_buf [N];

  logic                     w_last;
  logic signed [17:0]       w_dexp;
  logic signed [15:0]       w_d;
  logic signed [15:0]       w_log_out;
  logic signed [15:0]       w_lse;
  logic signed [15:0]       w_lse_sel;
  logic        [LOG2N-1:0]  w_oidx;
  logic signed [17:0]       w_dout;
  logic signed [15:0]       w_pow_in;
  logic        [15:0]       w_pow_out;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'sh7FFF;
    else if (v < -18'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  assign w_last = (r_idx == LOG2N'(N - 1));
  assign w_dexp = 18'(r_buf[r_idx]) - 18'(r_max);

`ifdef SOFTMAX_LOG2E_SCALE_EN
  logic signed [15:0] w_d0;
  logic signed [17:0] w_dsc;
  assign w_d0  = sat16(w_dexp);
  assign w_dsc = 18'(w_d0) + 18'(w_d0 >>> 1) - 18'(w_d0 >>> 4);
  assign w_d   = sat16(w_dsc);
`else
  assign w_d = sat16(w_dexp);
`endif

  // In LOG the first output is formed from the not-yet-registered lse so it is ready one cycle later
  assign w_lse     = w_log_out + 16'(LOG2N * 4096);
  assign w_lse_sel = (r_state == S_LOG) ? w_lse : r_lse;
  assign w_oidx    = (r_state == S_LOG) ? '0 : r_idx + 1'b1;
  assign w_dout    = 18'(r_buf[w_oidx]) - 18'(w_lse_sel);
  assign w_pow_in  = (r_state == S_EXP) ? w_d : sat16(w_dout);

  pow2_approx u_pow2 (.i_x(w_pow_in), .o_y(w_pow_out));
  log2_approx u_log2 (.i_x(r_acc[LOG2N +: 16]), .o_y(w_log_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: if (in_valid && w_last) w_next = S_EXP;
      S_EXP:  if (w_last) w_next = S_LOG;
      S_LOG:  w_next = S_OUT;
      S_OUT:  if (out_ready && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_max       <= '0;
      r_acc       <= '0;
      r_lse       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_idx <= '0;
          r_acc <= '0;
          r_max <= '0;
        end
        S_LOAD: if (in_valid) begin
          if (r_idx == '0 || in_data > r_max) r_max <= in_data;
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        S_EXP: begin
          r_acc <= r_acc + ACC_W'(w_pow_out);
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        S_LOG: begin
          r_lse       <= w_lse;
          r_out_data  <= w_pow_out;
          r_out_valid <= 1'b1;
          r_idx       <= '0;
        end
        S_OUT: if (out_ready) begin
          if (w_last) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_idx       <= '0;
          end else begin
            r_idx      <= r_idx + 1'b1;
            r_out_data <= w_pow_out;
          end
        end
        default: ;
      endcase
    end
  end

  // Element storage needs no reset: every entry is written in LOAD before it is read
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && in_valid) r_buf[r_idx] <= in_data;
    else if (r_state == S_EXP)         r_buf[r_idx] <= w_d;
  end

  assign busy      = (r_state != S_IDLE);
  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_valid && w_last;
  assign done      = r_done;
  assign dbg_state = r_state;
endmodule
